mem_port_sequencer: RTL and testbench
=====================================

Name: mem_port_sequencer

Overview:
- Shares one memory request/response port between the CPU's instruction-fetch side (imem) and data side (dmem).
- Drives global_stall_en so the whole pipeline advances exactly once per completed fetch, after any pending data access has finished.
- Sits between the cpu top level and the AXI master bridge. At most one transaction is outstanding at any time.

Parameters:
- XLEN, 32, address/data width.
- STRB_W, XLEN/8, write-strobe width.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  reset, asynchronous, active-high.
- imem_addr  in  XLEN  fetch address (current pc).
- imem_ren  in  1  fetch request; tied high by cpu.
- imem_rdata  out  XLEN  fetched instruction.
- imem_raddr_handshake  out  1  pulse: fetch address accepted.
- imem_rdata_handshake  out  1  pulse: fetch data returned.
- dmem_addr  in  XLEN  data address.
- dmem_ren  in  1  load request.
- dmem_wen  in  1  store request.
- dmem_wstrb  in  STRB_W  byte strobes.
- dmem_wdata  in  XLEN  store data.
- dmem_rdata  out  XLEN  load data.
- global_stall_en  out  1  pipeline-wide stall.
- mem_req_valid  out  1  shared request valid.
- mem_req_ready  in  1  shared request accepted.
- mem_req_addr  out  XLEN  request address.
- mem_req_we  out  1  1 = write.
- mem_req_wstrb  out  STRB_W  write strobes; 0 on reads.
- mem_req_wdata  out  XLEN  write data.
- mem_req_id  out  1  0 = imem, 1 = dmem.
- mem_resp_valid  in  1  response (read data or write ack).
- mem_resp_rdata  in  XLEN  response data.

Behaviour:
- States: IDLE, D_REQ, D_WAIT, I_REQ, I_WAIT. One "step" = optional data access, then one fetch.
- IDLE:
  - dmem_ren|dmem_wen -> D_REQ; else if imem_ren -> I_REQ; else stay.
  - Sampled only in IDLE. dmem_* are guaranteed stable because the pipeline is stalled.
- D_REQ:
  - mem_req_valid=1, id=1, addr=dmem_addr, we=dmem_wen, wstrb=dmem_wen?dmem_wstrb:0, wdata=dmem_wdata.
  - If dmem_ren and dmem_wen are both high, treat as write.
  - On mem_req_ready -> D_WAIT.
- D_WAIT:
  - On mem_resp_valid: if read, register dmem_rdata <= mem_resp_rdata; then -> I_REQ.
  - Writes leave dmem_rdata unchanged.
- I_REQ:
  - mem_req_valid=1, id=0, we=0, addr=imem_addr.
  - On mem_req_ready: imem_raddr_handshake=1 (that cycle) -> I_WAIT.
- I_WAIT:
  - On mem_resp_valid: imem_rdata_handshake=1, global_stall_en=0 (that cycle only), register copy of data -> IDLE.
- Request fields are held stable while mem_req_valid=1 and mem_req_ready=0. mem_req_valid never drops before acceptance.
- global_stall_en = 1 in every cycle except the I_WAIT response cycle. Consequence: the pipeline advances exactly one edge per step, and minimum step latency is 3 cycles (IDLE, I_REQ, I_WAIT) with zero-wait memory.
- imem_rdata = mem_resp_rdata combinationally during the I_WAIT response cycle, else the held register. The IF stage must see the instruction at the advancing edge.
- dmem_rdata is registered and stable from D_WAIT completion through the advancing edge.
- mem_resp_valid outside D_WAIT/I_WAIT is ignored; no state change.
- Reset (asynchronous, any state):
  - state=IDLE, mem_req_valid=0, all mem_req_* fields 0.
  - imem_rdata=0, dmem_rdata=0.
  - handshake pulses 0, global_stall_en=1.
  - An in-flight transaction is abandoned; the memory side is reset together.
- Deassertion of reset: first decision is made in the first IDLE cycle after release.

Test Plan:
- Fetch only, zero-wait memory, imem_addr=0x0000_0010, resp data 0x0000_0013:
  - mem_req_id=0 and valid in cycle 1.
  - Handshakes pulse in cycles 1/2.
  - global_stall_en low only in cycle 2 with imem_rdata=0x13.
  - Repeats every 3 cycles.
- Load dmem_ren=1, addr 0x1000, resp 0xDEADBEEF:
  - Data request (id=1, we=0, wstrb=0) issued before the fetch.
  - dmem_rdata=0xDEADBEEF held until the stall-low cycle.
  - global_stall_en low exactly once.
- Store dmem_wen=1, wstrb=4'b0011, wdata 0x1234_5678:
  - mem_req_we=1 with those fields.
  - dmem_rdata unchanged.
  - Fetch follows.
- Backpressure mem_req_ready=0 for 4 cycles in D_REQ:
  - valid/addr/wdata stable all 4 cycles.
  - No handshake pulses.
  - Stall stays high.
- Spurious mem_resp_valid in IDLE and I_REQ: no state change, no pulses, imem_rdata unchanged.
- ARESET asserted mid-D_WAIT:
  - Immediately mem_req_valid=0, global_stall_en=1, dmem_rdata=0.
  - After release, a fresh step starts from IDLE.

Source files
------------

// File: rtl/mem_port_sequencer.sv
// Arbitrates one memory request/response port between instruction fetch and data access.
// Each step is an optional data access followed by exactly one fetch, with the pipeline stalled until the fetch returns.
module mem_port_sequencer #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned STRB_W = XLEN / 8
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [XLEN-1:0]   imem_addr,
  input  logic              imem_ren,
  output logic [XLEN-1:0]   imem_rdata,
  output logic              imem_raddr_handshake,
  output logic              imem_rdata_handshake,
  input  logic [XLEN-1:0]   dmem_addr,
  input  logic              dmem_ren,
  input  logic              dmem_wen,
  input  logic [STRB_W-1:0] dmem_wstrb,
  input  logic [XLEN-1:0]   dmem_wdata,
  output logic [XLEN-1:0]   dmem_rdata,
  output logic              global_stall_en,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [XLEN-1:0]   mem_req_addr,
  output logic              mem_req_we,
  output logic [STRB_W-1:0] mem_req_wstrb,
  output logic [XLEN-1:0]   mem_req_wdata,
  output logic              mem_req_id,
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_resp_rdata
);

  typedef enum logic [2:0] {
    StIdle,
    StDReq,
    StDWait,
    StIReq,
    StIWait
  } state_e;

  state_e            r_state;
  state_e            w_state_next;
  logic              r_d_write;
  logic [XLEN-1:0]   r_imem_rdata;
  logic [XLEN-1:0]   r_dmem_rdata;
  logic              w_i_resp;

  assign w_i_resp = (r_state == StIWait) && mem_resp_valid;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state      <= StIdle;
      r_d_write    <= 1'b0;
      r_imem_rdata <= '0;
      r_dmem_rdata <= '0;
    end else begin
      r_state <= w_state_next;
      // Both ren and wen high is treated as a write.
      if (r_state == StIdle && (dmem_ren || dmem_wen)) begin
        r_d_write <= dmem_wen;
      end
      if (r_state == StDWait && mem_resp_valid && !r_d_write) begin
        r_dmem_rdata <= mem_resp_rdata;
      end
      if (w_i_resp) begin
        r_imem_rdata <= mem_resp_rdata;
      end
    end
  end

  always_comb begin
    w_state_next         = r_state;
    mem_req_valid        = 1'b0;
    mem_req_addr         = '0;
    mem_req_we           = 1'b0;
    mem_req_wstrb        = '0;
    mem_req_wdata        = '0;
    mem_req_id           = 1'b0;
    imem_raddr_handshake = 1'b0;
    imem_rdata_handshake = 1'b0;
    global_stall_en      = 1'b1;
    unique case (r_state)
      StIdle: begin
        if (dmem_ren || dmem_wen) begin
          w_state_next = StDReq;
        end else if (imem_ren) begin
          w_state_next = StIReq;
        end
      end
      StDReq: begin
        mem_req_valid = 1'b1;
        mem_req_id    = 1'b1;
        mem_req_addr  = dmem_addr;
        mem_req_we    = r_d_write;
        mem_req_wstrb = r_d_write ? dmem_wstrb : '0;
        mem_req_wdata = dmem_wdata;
        if (mem_req_ready) begin
          w_state_next = StDWait;
        end
      end
      StDWait: begin
        if (mem_resp_valid) begin
          w_state_next = StIReq;
        end
      end
      StIReq: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = imem_addr;
        if (mem_req_ready) begin
          imem_raddr_handshake = 1'b1;
          w_state_next         = StIWait;
        end
      end
      StIWait: begin
        if (mem_resp_valid) begin
          imem_rdata_handshake = 1'b1;
          global_stall_en      = 1'b0;
          w_state_next         = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Bypass so the IF stage sees the instruction at the advancing edge.
  assign imem_rdata = w_i_resp ? mem_resp_rdata : r_imem_rdata;
  assign dmem_rdata = r_dmem_rdata;

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Directed bench for mem_port_sequencer: fetch, load, store, backpressure, spurious responses and
// asynchronous reset, with hand-computed expectations checked by immediate assertions.
module tb_mem_port_sequencer;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [31:0] imem_addr;
  logic        imem_ren;
  logic [31:0] imem_rdata;
  logic        imem_raddr_handshake;
  logic        imem_rdata_handshake;
  logic [31:0] dmem_addr;
  logic        dmem_ren;
  logic        dmem_wen;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        global_stall_en;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_we;
  logic [3:0]  mem_req_wstrb;
  logic [31:0] mem_req_wdata;
  logic        mem_req_id;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 ACLK = ~ACLK;

  mem_port_sequencer #(.XLEN(32), .STRB_W(4)) dut (
    .ACLK                 (ACLK),
    .ARESET               (ARESET),
    .imem_addr            (imem_addr),
    .imem_ren             (imem_ren),
    .imem_rdata           (imem_rdata),
    .imem_raddr_handshake (imem_raddr_handshake),
    .imem_rdata_handshake (imem_rdata_handshake),
    .dmem_addr            (dmem_addr),
    .dmem_ren             (dmem_ren),
    .dmem_wen             (dmem_wen),
    .dmem_wstrb           (dmem_wstrb),
    .dmem_wdata           (dmem_wdata),
    .dmem_rdata           (dmem_rdata),
    .global_stall_en      (global_stall_en),
    .mem_req_valid        (mem_req_valid),
    .mem_req_ready        (mem_req_ready),
    .mem_req_addr         (mem_req_addr),
    .mem_req_we           (mem_req_we),
    .mem_req_wstrb        (mem_req_wstrb),
    .mem_req_wdata        (mem_req_wdata),
    .mem_req_id           (mem_req_id),
    .mem_resp_valid       (mem_resp_valid),
    .mem_resp_rdata       (mem_resp_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Outputs in a cycle with no handshake and stall high.
  task automatic chk_quiet(input string tag);
    chk1({tag, ".rhs"}, imem_raddr_handshake, 1'b0);
    chk1({tag, ".dhs"}, imem_rdata_handshake, 1'b0);
    chk1({tag, ".stall"}, global_stall_en, 1'b1);
  endtask

  initial begin
    ARESET         = 1'b1;
    imem_addr      = 32'h0000_0010;
    imem_ren       = 1'b1;
    dmem_addr      = '0;
    dmem_ren       = 1'b0;
    dmem_wen       = 1'b0;
    dmem_wstrb     = '0;
    dmem_wdata     = '0;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    #1;
    chk1("rst.valid", mem_req_valid, 1'b0);
    chk("rst.addr", mem_req_addr, 32'h0);
    chk("rst.irdata", imem_rdata, 32'h0);
    chk("rst.drdata", dmem_rdata, 32'h0);
    chk_quiet("rst");
    ARESET = 1'b0;
    #1;
    // Cycle 0: IDLE
    chk1("f0.valid", mem_req_valid, 1'b0);
    chk_quiet("f0");

    // Fetch only, zero-wait
    tick();  // cycle 1: I_REQ
    chk1("f1.valid", mem_req_valid, 1'b1);
    chk1("f1.id", mem_req_id, 1'b0);
    chk1("f1.we", mem_req_we, 1'b0);
    chk("f1.addr", mem_req_addr, 32'h0000_0010);
    chk1("f1.rhs", imem_raddr_handshake, 1'b1);
    chk1("f1.stall", global_stall_en, 1'b1);
    tick();  // cycle 2: I_WAIT
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'h0000_0013;
    #1;
    chk1("f2.valid", mem_req_valid, 1'b0);
    chk1("f2.rhs", imem_raddr_handshake, 1'b0);
    chk1("f2.dhs", imem_rdata_handshake, 1'b1);
    chk1("f2.stall", global_stall_en, 1'b0);
    chk("f2.irdata", imem_rdata, 32'h0000_0013);
    tick();  // cycle 3: IDLE
    mem_resp_valid = 1'b0;
    mem_resp_rdata = 32'hFFFF_FFFF;
    #1;
    chk1("f3.valid", mem_req_valid, 1'b0);
    chk("f3.irdata", imem_rdata, 32'h0000_0013);
    chk_quiet("f3");
    tick();  // cycle 4: I_REQ again
    chk1("f4.valid", mem_req_valid, 1'b1);
    chk1("f4.rhs", imem_raddr_handshake, 1'b1);
    tick();  // cycle 5: I_WAIT
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'h0000_0093;
    #1;
    chk1("f5.stall", global_stall_en, 1'b0);
    chk("f5.irdata", imem_rdata, 32'h0000_0093);

    // Load
    tick();  // IDLE
    mem_resp_valid = 1'b0;
    dmem_ren  = 1'b1;
    dmem_addr = 32'h0000_1000;
    #1;
    chk_quiet("l0");
    tick();  // D_REQ
    chk1("l1.valid", mem_req_valid, 1'b1);
    chk1("l1.id", mem_req_id, 1'b1);
    chk1("l1.we", mem_req_we, 1'b0);
    chk("l1.wstrb", 32'(mem_req_wstrb), 32'h0);
    chk("l1.addr", mem_req_addr, 32'h0000_1000);
    chk_quiet("l1");
    tick();  // D_WAIT
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'hDEAD_BEEF;
    #1;
    chk1("l2.valid", mem_req_valid, 1'b0);
    chk_quiet("l2");
    tick();  // I_REQ
    mem_resp_valid = 1'b0;
    #1;
    chk("l3.drdata", dmem_rdata, 32'hDEAD_BEEF);
    chk1("l3.id", mem_req_id, 1'b0);
    chk("l3.addr", mem_req_addr, 32'h0000_0010);
    chk1("l3.stall", global_stall_en, 1'b1);
    tick();  // I_WAIT
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'h0000_0013;
    #1;
    chk1("l4.stall", global_stall_en, 1'b0);
    chk("l4.drdata", dmem_rdata, 32'hDEAD_BEEF);
    chk("l4.irdata", imem_rdata, 32'h0000_0013);
    tick();  // IDLE
    mem_resp_valid = 1'b0;
    dmem_ren   = 1'b0;
    // Store
    dmem_wen   = 1'b1;
    dmem_addr  = 32'h0000_2000;
    dmem_wstrb = 4'b0011;
    dmem_wdata = 32'h1234_5678;
    #1;
    chk1("l5.stall", global_stall_en, 1'b1);
    tick();  // D_REQ
    chk1("s1.valid", mem_req_valid, 1'b1);
    chk1("s1.id", mem_req_id, 1'b1);
    chk1("s1.we", mem_req_we, 1'b1);
    chk("s1.wstrb", 32'(mem_req_wstrb), 32'h3);
    chk("s1.wdata", mem_req_wdata, 32'h1234_5678);
    chk("s1.addr", mem_req_addr, 32'h0000_2000);
    tick();  // D_WAIT
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'hCAFE_F00D;
    #1;
    chk_quiet("s2");
    tick();  // I_REQ
    mem_resp_valid = 1'b0;
    #1;
    chk("s3.drdata", dmem_rdata, 32'hDEAD_BEEF);
    chk1("s3.id", mem_req_id, 1'b0);
    chk1("s3.rhs", imem_raddr_handshake, 1'b1);
    tick();  // I_WAIT
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'h0000_0033;
    #1;
    chk1("s4.stall", global_stall_en, 1'b0);

    // Backpressure in D_REQ
    tick();  // IDLE
    mem_resp_valid = 1'b0;
    dmem_addr     = 32'h0000_3000;
    dmem_wdata    = 32'hA5A5_A5A5;
    dmem_wstrb    = 4'hF;
    mem_req_ready = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk1("bp.valid", mem_req_valid, 1'b1);
      chk("bp.addr", mem_req_addr, 32'h0000_3000);
      chk("bp.wdata", mem_req_wdata, 32'hA5A5_A5A5);
      chk_quiet("bp");
    end
    mem_req_ready = 1'b1;
    #1;
    chk1("bp.acc", mem_req_valid, 1'b1);
    tick();  // D_WAIT
    chk1("bp.dwait", mem_req_valid, 1'b0);
    mem_resp_valid = 1'b1;
    dmem_wen = 1'b0;
    #1;
    tick();  // I_REQ: spurious response with ready low
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'h0000_0055;
    #1;
    chk_quiet("sp1");
    chk("sp1.irdata", imem_rdata, 32'h0000_0033);
    tick();  // still I_REQ
    chk1("sp2.valid", mem_req_valid, 1'b1);
    chk1("sp2.id", mem_req_id, 1'b0);
    chk_quiet("sp2");
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b0;
    #1;
    chk1("sp2.rhs", imem_raddr_handshake, 1'b1);
    tick();  // I_WAIT
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'h0000_0073;
    #1;
    chk1("sp3.stall", global_stall_en, 1'b0);
    tick();  // IDLE: spurious response, no fetch request
    imem_ren       = 1'b0;
    mem_resp_rdata = 32'h0000_0077;
    #1;
    chk_quiet("sp4");
    chk("sp4.irdata", imem_rdata, 32'h0000_0073);
    tick();
    chk1("sp5.valid", mem_req_valid, 1'b0);
    chk_quiet("sp5");
    chk("sp5.irdata", imem_rdata, 32'h0000_0073);

    // Reset mid-D_WAIT
    mem_resp_valid = 1'b0;
    imem_ren  = 1'b1;
    dmem_ren  = 1'b1;
    dmem_addr = 32'h0000_1000;
    tick();  // D_REQ
    chk1("r1.valid", mem_req_valid, 1'b1);
    tick();  // D_WAIT
    chk("r2.drdata", dmem_rdata, 32'hDEAD_BEEF);
    ARESET = 1'b1;
    #1;
    chk1("r3.valid", mem_req_valid, 1'b0);
    chk1("r3.stall", global_stall_en, 1'b1);
    chk("r3.drdata", dmem_rdata, 32'h0);
    chk("r3.irdata", imem_rdata, 32'h0);
    dmem_ren = 1'b0;
    #1;
    ARESET = 1'b0;
    tick();  // fresh step: I_REQ
    chk1("r4.valid", mem_req_valid, 1'b1);
    chk1("r4.id", mem_req_id, 1'b0);
    chk("r4.addr", mem_req_addr, 32'h0000_0010);
    tick();  // I_WAIT
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'h0000_0013;
    #1;
    chk1("r5.stall", global_stall_en, 1'b0);
    chk1("r5.dhs", imem_rdata_handshake, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
